// File: rtl/hurricane_ctrl.sv
// Hurricane (mode 3) sequencer: run countdown, menu-triggered exit countdown and once-per-power-on lockout.
// Optional re-arm after lockout is compiled in with `define HURRICANE_COOLDOWN_EN.
module hurricane_ctrl #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned RUN_SEC      = 60,
    parameter int unsigned EXIT_SEC     = 60,
    parameter int unsigned COOLDOWN_SEC = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic [2:0] mode_state,
    input  logic       menu_btn,
    output logic       hurricane_mode_enabled,
    output logic       return_state,
    output logic       hurricane_active,
    output logic [7:0] countdown,
    output logic       expired
);

    localparam int unsigned    PW             = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PS_MAX         = PW'(CLK_HZ - 1);
    localparam logic [7:0]     RUN_LOAD       = 8'(RUN_SEC);
    localparam logic [7:0]     EXIT_LOAD      = 8'(EXIT_SEC);
    localparam logic [2:0]     MODE_HURRICANE = 3'b011;
`ifdef HURRICANE_COOLDOWN_EN
    localparam logic [7:0]     LOCK_LOAD      = 8'(COOLDOWN_SEC);
`else
    localparam logic [7:0]     LOCK_LOAD      = 8'd0;
`endif

    typedef enum logic [2:0] {
        ST_READY,
        ST_RUN,
        ST_EXIT,
        ST_RELEASE,
        ST_LOCKED
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          menu_prev;
    logic          tick;
    logic          menu_press;
    logic          in_hurricane;

    assign tick         = (prescaler == PS_MAX);
    assign menu_press   = menu_btn & ~menu_prev;
    assign in_hurricane = (mode_state == MODE_HURRICANE);

    // Every state change clears the prescaler so each interval starts with a full second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= ST_READY;
            prescaler              <= '0;
            menu_prev              <= 1'b0;
            hurricane_mode_enabled <= 1'b1;
            return_state           <= 1'b1;
            hurricane_active       <= 1'b0;
            countdown              <= 8'd0;
            expired                <= 1'b0;
        end else begin
            menu_prev <= menu_btn;
            expired   <= 1'b0;
            prescaler <= tick ? '0 : prescaler + 1'b1;

            if (!machine_state) begin
                state                  <= ST_READY;
                prescaler              <= '0;
                hurricane_mode_enabled <= 1'b1;
                return_state           <= 1'b1;
                hurricane_active       <= 1'b0;
                countdown              <= 8'd0;
            end else begin
                case (state)
                    ST_READY: begin
                        if (in_hurricane) begin
                            state                  <= ST_RUN;
                            prescaler              <= '0;
                            countdown              <= RUN_LOAD;
                            hurricane_mode_enabled <= 1'b1;
                            return_state           <= 1'b1;
                            hurricane_active       <= 1'b1;
                        end
                    end

                    // External abort beats a menu press, which beats the final tick.
                    ST_RUN: begin
                        if (!in_hurricane) begin
                            state                  <= ST_LOCKED;
                            prescaler              <= '0;
                            countdown              <= LOCK_LOAD;
                            hurricane_mode_enabled <= 1'b0;
                            return_state           <= 1'b1;
                            hurricane_active       <= 1'b0;
                        end else if (menu_press) begin
                            state        <= ST_EXIT;
                            prescaler    <= '0;
                            countdown    <= EXIT_LOAD;
                            return_state <= 1'b0;
                        end else if (tick) begin
                            if (countdown == 8'd1) begin
                                state                  <= ST_RELEASE;
                                prescaler              <= '0;
                                countdown              <= 8'd0;
                                expired                <= 1'b1;
                                hurricane_mode_enabled <= 1'b0;
                                hurricane_active       <= 1'b0;
                            end else if (countdown != 8'd0) begin
                                countdown <= countdown - 8'd1;
                            end
                        end
                    end

                    ST_EXIT: begin
                        if (!in_hurricane) begin
                            state                  <= ST_LOCKED;
                            prescaler              <= '0;
                            countdown              <= LOCK_LOAD;
                            hurricane_mode_enabled <= 1'b0;
                            return_state           <= 1'b1;
                            hurricane_active       <= 1'b0;
                        end else if (tick) begin
                            if (countdown == 8'd1) begin
                                state                  <= ST_RELEASE;
                                prescaler              <= '0;
                                countdown              <= 8'd0;
                                expired                <= 1'b1;
                                hurricane_mode_enabled <= 1'b0;
                                hurricane_active       <= 1'b0;
                            end else if (countdown != 8'd0) begin
                                countdown <= countdown - 8'd1;
                            end
                        end
                    end

                    ST_RELEASE: begin
                        if (!in_hurricane) begin
                            state                  <= ST_LOCKED;
                            prescaler              <= '0;
                            countdown              <= LOCK_LOAD;
                            hurricane_mode_enabled <= 1'b0;
                            return_state           <= 1'b1;
                            hurricane_active       <= 1'b0;
                        end
                    end

                    ST_LOCKED: begin
`ifdef HURRICANE_COOLDOWN_EN
                        if (tick && countdown != 8'd0) begin
                            if (countdown == 8'd1) begin
                                state                  <= ST_READY;
                                prescaler              <= '0;
                                countdown              <= 8'd0;
                                hurricane_mode_enabled <= 1'b1;
                                return_state           <= 1'b1;
                            end else begin
                                countdown <= countdown - 8'd1;
                            end
                        end
`else
                        hurricane_mode_enabled <= 1'b0;
                        return_state           <= 1'b1;
                        countdown              <= 8'd0;
`endif
                    end

                    default: begin
                        state                  <= ST_READY;
                        prescaler              <= '0;
                        hurricane_mode_enabled <= 1'b1;
                        return_state           <= 1'b1;
                        hurricane_active       <= 1'b0;
                        countdown              <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hurricane_ctrl.md
Name: hurricane_ctrl

Overview:
- Sequencer for the range-hood hurricane (mode 3) function. It drives the mode FSM's `hurricane_mode_enabled` and `return_state` inputs.
- Runs the hurricane run-time countdown and the menu-triggered exit countdown, then enforces the once-per-power-on lockout.
- Sits between the power/mode FSM and the display driver; exports remaining seconds for the seven-segment display.

Parameters:
- CLK_HZ, 100_000_000, clk cycles per second tick
- RUN_SEC, 60, hurricane run time before automatic drop to mode 2
- EXIT_SEC, 60, delay after menu press in hurricane before return to standby
- COOLDOWN_SEC, 30, re-arm delay (only with HURRICANE_COOLDOWN_EN)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- machine_state  input  1  1 = hood powered on
- mode_state  input  3  current mode from mode FSM (3'b011 = hurricane)
- menu_btn  input  1  debounced menu button level
- hurricane_mode_enabled  output  1  1 = hurricane may be entered / held
- return_state  output  1  exit target: 1 = mode 2, 0 = standby
- hurricane_active  output  1  1 while in RUN or EXIT
- countdown  output  8  remaining seconds of the current RUN/EXIT interval, else 0
- expired  output  1  one-cycle pulse when a RUN or EXIT interval reaches 0

Behaviour:
- Reset (rst=0, async): state READY; prescaler=0; menu_prev=0.
  - Outputs: hurricane_mode_enabled=1, return_state=1, hurricane_active=0, countdown=0, expired=0.
- Prescaler: counts 0..CLK_HZ-1; tick is asserted on the cycle the count equals CLK_HZ-1. Cleared on every state entry, so the first decrement occurs a full CLK_HZ cycles after entry.
- Menu edge: menu_press = menu_btn & ~menu_prev, registered every cycle.
- States:
  - READY (enabled=1, return_state=1, countdown=0): mode_state==3'b011 -> RUN, countdown<=RUN_SEC.
  - RUN (enabled=1, return_state=1, active=1):
    - tick decrements countdown.
    - tick with countdown==1 -> countdown 0, expired pulse, RELEASE with return_state=1.
    - menu_press -> EXIT, countdown<=EXIT_SEC, return_state<=0.
    - mode_state!=3'b011 -> LOCKED (external abort).
  - EXIT (enabled=1, return_state=0, active=1): tick decrements; tick with countdown==1 -> expired pulse, RELEASE with return_state=0. Further menu presses are ignored.
  - RELEASE (enabled=0, return_state held): the mode FSM sees enabled=0 and leaves mode 3. When mode_state!=3'b011 -> LOCKED.
  - LOCKED (enabled=0, return_state=1, countdown=0): hurricane cannot be entered again until power-off.
- Priorities:
  - machine_state==0 overrides everything, synchronously: next cycle READY, outputs at their reset values.
  - A menu_press and a final tick in the same RUN cycle -> menu wins (EXIT).
  - A tick with countdown==1 in the same cycle as external mode exit -> LOCKED, with no expired pulse.
- Width: countdown is 8-bit unsigned. RUN_SEC, EXIT_SEC and COOLDOWN_SEC must be 1..255. No underflow: countdown never decrements below 0.
- Outputs are registered and change one cycle after the causing input.

Optional Feature:
- HURRICANE_COOLDOWN_EN:
  - Defined: LOCKED loads countdown<=COOLDOWN_SEC and ticks down; reaching 0 -> READY (enabled=1). countdown shows the cooldown remaining.
  - Undefined: LOCKED persists until machine_state==0, with countdown=0.

Test Plan (CLK_HZ=10, RUN_SEC=5, EXIT_SEC=3, COOLDOWN_SEC=2):
- Power on, mode_state=3'b011 held -> countdown 5,4,3,2,1,0 at 10-cycle steps. expired pulses once; enabled=0, return_state=1.
- Then mode_state=3'b010 -> LOCKED. Re-drive 3'b011 -> enabled stays 0, countdown=0.
- In RUN at countdown=3, menu press -> countdown=3, return_state=0. After 30 cycles enabled=0 with return_state=0.
- RUN at countdown=2, machine_state->0 -> next cycle READY, enabled=1, countdown=0, active=0. Re-entering 3'b011 reloads 5.
- rst low mid-EXIT -> outputs immediately 1,1,0,0,0 (enabled, return_state, active, countdown, expired).
- With HURRICANE_COOLDOWN_EN: after LOCKED entry, countdown 2,1,0 over 20 cycles, then enabled=1 and READY.
